// File: rtl/sensor_node.sv
// sensor_node: polled UART slave that answers its ID with a data byte and a serially computed CRC-8.
// Optional macro SENSOR_NODE_STATS_EN adds saturating poll_count / crc_tx_count outputs.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for an address byte; only state that acks rx_rdy
//   CALC    | one CRC bit per cycle over the captured data byte
//   WAIT_TA | holding off until the bus turnaround gap has elapsed
//   SEND_D  | data byte ready; strobe tx_wr once the UART is free
//   WAIT_D  | data byte in flight (busy rise/fall or 4-cycle fallback)
//   SEND_C  | CRC byte ready (inverted when an alarm is latched)
//   WAIT_C  | CRC byte in flight, then back to IDLE
module sensor_node #(
    parameter logic [2:0]  NODE_ID    = 3'd1,
    parameter int unsigned TURNAROUND = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        rx_clr,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    input  logic [7:0]  sensor_value,
    input  logic        sensor_valid,
    input  logic        alarm,
    output logic        alarm_pending,
    output logic        busy
`ifdef SENSOR_NODE_STATS_EN
   ,output logic [15:0] poll_count,
    output logic [15:0] crc_tx_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CALC, ST_WAIT_TA, ST_SEND_D, ST_WAIT_D, ST_SEND_C, ST_WAIT_C
    } state_t;

    localparam logic [7:0] TA_LOAD = 8'(TURNAROUND - 1);
    localparam logic [7:0] FB_LOAD = 8'd3;

    state_t      state_q, state_d;
    logic [7:0]  sample_q, sample_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  crc_q, crc_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  tmr_q, tmr_d;
    logic        seen_q, seen_d;
    logic        alarm_q, alarm_d;
    logic        rx_clr_q, rx_clr_d;

    logic        accept, own_hit, bcast_hit;
    logic        ta_done, ack_done, waiting;
    logic        crc_fb;
    logic [7:0]  crc_next;
    logic        unused_rx_hi;

    // rx_clr_q masks the cycle in which the UART has not yet dropped rx_rdy
    assign accept    = (state_q == ST_IDLE) && rx_rdy && !rx_clr_q;
    assign own_hit   = accept && (rx_data[2:0] == NODE_ID);
    assign bcast_hit = accept && (rx_data[2:0] == 3'd0);
    assign unused_rx_hi = ^rx_data[7:3];

    assign ta_done  = (tmr_q <= 8'd1);
    assign waiting  = (state_q == ST_WAIT_D) || (state_q == ST_WAIT_C);
    assign ack_done = !tx_busy && (seen_q || (tmr_q == 8'd0));

    assign crc_fb   = crc_q[7] ^ data_q[3'd7 - bit_cnt_q];
    assign crc_next = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sample_q  <= 8'h00;
            data_q    <= 8'h00;
            crc_q     <= 8'h00;
            bit_cnt_q <= 3'd0;
            tmr_q     <= 8'h00;
            seen_q    <= 1'b0;
            alarm_q   <= 1'b0;
            rx_clr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            data_q    <= data_d;
            crc_q     <= crc_d;
            bit_cnt_q <= bit_cnt_d;
            tmr_q     <= tmr_d;
            seen_q    <= seen_d;
            alarm_q   <= alarm_d;
            rx_clr_q  <= rx_clr_d;
        end
    end

    // CALC exits straight to SEND_D when the turnaround gap is already covered
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (own_hit) state_d = ST_CALC;
            ST_CALC:    if (bit_cnt_q == 3'd7) state_d = ta_done ? ST_SEND_D : ST_WAIT_TA;
            ST_WAIT_TA: if (ta_done) state_d = ST_SEND_D;
            ST_SEND_D:  if (!tx_busy) state_d = ST_WAIT_D;
            ST_WAIT_D:  if (ack_done) state_d = ST_SEND_C;
            ST_SEND_C:  if (!tx_busy) state_d = ST_WAIT_C;
            ST_WAIT_C:  if (ack_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_wr         = 1'b0;
        tx_data       = 8'h00;
        rx_clr        = rx_clr_q;
        alarm_pending = alarm_q;
        busy          = (state_q != ST_IDLE);
        if (state_q == ST_SEND_D) begin
            tx_wr   = !tx_busy;
            tx_data = data_q;
        end else if (state_q == ST_SEND_C) begin
            tx_wr   = !tx_busy;
            tx_data = crc_q ^ {8{alarm_q}};
        end
    end

    // one timer serves both the turnaround gap and the tx_busy fallback
    always_comb begin
        sample_d  = sensor_valid ? sensor_value : sample_q;
        data_d    = own_hit ? sample_q : data_q;
        crc_d     = crc_q;
        bit_cnt_d = bit_cnt_q;
        if (own_hit) begin
            crc_d     = 8'h00;
            bit_cnt_d = 3'd0;
        end else if (state_q == ST_CALC) begin
            crc_d     = crc_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (own_hit)
            tmr_d = TA_LOAD;
        else if (tx_wr)
            tmr_d = FB_LOAD;
        else if (tmr_q != 8'd0)
            tmr_d = tmr_q - 8'd1;
        else
            tmr_d = tmr_q;
        if (tx_wr)
            seen_d = 1'b0;
        else if (waiting && tx_busy)
            seen_d = 1'b1;
        else
            seen_d = seen_q;
        alarm_d  = alarm | (alarm_q & !bcast_hit);
        rx_clr_d = accept;
    end

`ifdef SENSOR_NODE_STATS_EN
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [15:0] crc_cnt_q, crc_cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            poll_cnt_q <= 16'h0000;
            crc_cnt_q  <= 16'h0000;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            crc_cnt_q  <= crc_cnt_d;
        end
    end

    always_comb begin
        poll_cnt_d = poll_cnt_q;
        crc_cnt_d  = crc_cnt_q;
        if (own_hit && (poll_cnt_q != 16'hFFFF))
            poll_cnt_d = poll_cnt_q + 16'd1;
        if ((state_q == ST_SEND_C) && tx_wr && (crc_cnt_q != 16'hFFFF))
            crc_cnt_d = crc_cnt_q + 16'd1;
    end

    assign poll_count   = poll_cnt_q;
    assign crc_tx_count = crc_cnt_q;
`endif

endmodule

// File: tb/tb_sensor_node.sv
// tb_sensor_node: table-driven poll/reply vectors plus hand-written busy-hold, fallback,
// mid-frame reset and pending-byte sequences for sensor_node (NODE_ID=1, TURNAROUND=4).
module tb_sensor_node;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        rx_clr;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [7:0]  sensor_value;
    logic        sensor_valid;
    logic        alarm;
    logic        alarm_pending;
    logic        busy;
`ifdef SENSOR_NODE_STATS_EN
    logic [15:0] poll_count;
    logic [15:0] crc_tx_count;
`endif

    sensor_node #(.NODE_ID(3'd1), .TURNAROUND(4)) dut (
        .clock(clock), .reset(reset),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_clr(rx_clr),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .sensor_value(sensor_value), .sensor_valid(sensor_valid),
        .alarm(alarm), .alarm_pending(alarm_pending), .busy(busy)
`ifdef SENSOR_NODE_STATS_EN
       ,.poll_count(poll_count), .crc_tx_count(crc_tx_count)
`endif
    );

    always #10 clock = ~clock;

    typedef struct {
        logic       do_sample;
        logic [7:0] sample;
        logic       do_alarm;
        logic [7:0] addr;
        int         n_bytes;
        logic [7:0] exp_d;
        logic [7:0] exp_c;
        logic       exp_alarm;
    } vec_t;

    vec_t       vecs[10];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         n_clr = 0;
    int         clr_cyc = 0;
    int         n_wr_busy = 0;
    int         busy_left = 0;
    int         busy_len = 6;
    logic       hold_busy = 1'b0;
    logic       busy_seen = 1'b0;
    logic [7:0] cap[$];
    int         cap_cyc[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // monitor: one step per cycle at the falling edge
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (rx_clr) begin
                n_clr++;
                clr_cyc = cyc;
            end
            if (busy) busy_seen = 1'b1;
            if (tx_wr) begin
                cap.push_back(tx_data);
                cap_cyc.push_back(cyc);
                if (tx_busy) n_wr_busy++;
                busy_left = busy_len;
            end
        end
    end

    // UART transmitter model: busy for busy_len cycles after each strobe
    initial begin
        tx_busy = 1'b0;
        forever begin
            tick();
            if (hold_busy)
                tx_busy = 1'b1;
            else if (busy_left > 0) begin
                tx_busy = 1'b1;
                busy_left--;
            end else
                tx_busy = 1'b0;
        end
    end

    task automatic send_addr(input logic [7:0] a);
        bit got;
        got = 1'b0;
        tick();
        rx_data = a;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (rx_clr) begin
                got = 1'b1;
                break;
            end
        end
        check("rx_clr_timeout", int'(got), 1);
        tick();
        rx_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", int'(ok), 1);
        repeat (4) @(negedge clock);
    endtask

    task automatic pulse_sample(input logic [7:0] v);
        tick();
        sensor_value = v;
        sensor_valid = 1'b1;
        tick();
        sensor_valid = 1'b0;
    endtask

    task automatic pulse_alarm();
        tick();
        alarm = 1'b1;
        tick();
        alarm = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_log();
        cap.delete();
        cap_cyc.delete();
        n_clr = 0;
        busy_seen = 1'b0;
    endtask

    initial begin
        bit ok;
        vecs[0] = '{1'b0, 8'h00, 1'b0, 8'h01, 2, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 8'h01, 1'b0, 8'h01, 2, 8'h01, 8'h07, 1'b0};
        vecs[2] = '{1'b1, 8'h80, 1'b1, 8'h01, 2, 8'h80, 8'h76, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 0, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 8'h03, 0, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 8'hF2, 0, 8'h00, 8'h00, 1'b0};
        vecs[6] = '{1'b1, 8'hA5, 1'b0, 8'h09, 2, 8'hA5, 8'h72, 1'b0};
        vecs[7] = '{1'b1, 8'hFF, 1'b1, 8'h01, 2, 8'hFF, 8'h0C, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 8'h05, 0, 8'h00, 8'h00, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 8'h08, 0, 8'h00, 8'h00, 1'b0};

        reset = 1'b1;
        rx_data = 8'h00;
        rx_rdy = 1'b0;
        sensor_value = 8'h00;
        sensor_valid = 1'b0;
        alarm = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_rx_clr", int'(rx_clr), 0);
        check("rst_tx_wr", int'(tx_wr), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_alarm", int'(alarm_pending), 0);
        check("rst_busy", int'(busy), 0);

        for (int i = 0; i < 10; i++) begin
            clear_log();
            if (vecs[i].do_sample) pulse_sample(vecs[i].sample);
            if (vecs[i].do_alarm) pulse_alarm();
            send_addr(vecs[i].addr);
            wait_idle();
            check($sformatf("vec%0d_nbytes", i), cap.size(), vecs[i].n_bytes);
            if (vecs[i].n_bytes == 2 && cap.size() == 2) begin
                check($sformatf("vec%0d_data", i), int'(cap[0]), int'(vecs[i].exp_d));
                check($sformatf("vec%0d_crc", i), int'(cap[1]), int'(vecs[i].exp_c));
            end
            check($sformatf("vec%0d_busy", i), int'(busy_seen), int'(vecs[i].n_bytes != 0));
            check($sformatf("vec%0d_rx_clr", i), n_clr, 1);
            check($sformatf("vec%0d_alarm", i), int'(alarm_pending), int'(vecs[i].exp_alarm));
            if (i == 1 && cap_cyc.size() == 2) begin
                check("latency", cap_cyc[0] - clr_cyc + 1, 9);
                check("gap_busy", cap_cyc[1] - cap_cyc[0], 8);
            end
        end

        // tx_busy stuck high: data byte must wait, then go out exactly once
        clear_log();
        pulse_sample(8'h5A);
        hold_busy = 1'b1;
        send_addr(8'h01);
        repeat (50) @(negedge clock);
        check("hold_no_wr", cap.size(), 0);
        check("hold_busy_out", int'(busy), 1);
        hold_busy = 1'b0;
        wait_idle();
        check("hold_nbytes", cap.size(), 2);
        if (cap.size() == 2) begin
            check("hold_data", int'(cap[0]), 8'h5A);
            check("hold_crc", int'(cap[1]), 8'h81);
        end

        // tx_busy never rises: 4-cycle fallback advances to CRC byte
        clear_log();
        busy_len = 0;
        pulse_sample(8'hC3);
        send_addr(8'h01);
        wait_idle();
        check("fb_nbytes", cap.size(), 2);
        if (cap.size() == 2) begin
            check("fb_data", int'(cap[0]), 8'hC3);
            check("fb_crc", int'(cap[1]), 8'h47);
            check("fb_gap", cap_cyc[1] - cap_cyc[0], 5);
        end
        busy_len = 6;

        // reset while the data byte is in flight
        clear_log();
        pulse_sample(8'h99);
        pulse_alarm();
        send_addr(8'h01);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (cap.size() >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_first_byte", int'(ok), 1);
        repeat (2) @(negedge clock);
        check("mid_alarm_set", int'(alarm_pending), 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_rx_clr", int'(rx_clr), 0);
        check("mid_rst_tx_wr", int'(tx_wr), 0);
        check("mid_rst_tx_data", int'(tx_data), 0);
        check("mid_rst_alarm", int'(alarm_pending), 0);
        repeat (30) @(negedge clock);
        check("mid_no_crc", cap.size(), 1);
        clear_log();
        pulse_sample(8'h3C);
        send_addr(8'h01);
        wait_idle();
        check("post_rst_nbytes", cap.size(), 2);
        if (cap.size() == 2) begin
            check("post_rst_data", int'(cap[0]), 8'h3C);
            check("post_rst_crc", int'(cap[1]), 8'hB4);
        end

        // second poll arrives mid-frame; later sample must not leak into frame 1
        clear_log();
        pulse_sample(8'h11);
        send_addr(8'h01);
        pulse_sample(8'h22);
        send_addr(8'h01);
        wait_idle();
        check("pend_nbytes", cap.size(), 4);
        check("pend_rx_clr", n_clr, 2);
        if (cap.size() == 4) begin
            check("pend_d0", int'(cap[0]), 8'h11);
            check("pend_c0", int'(cap[1]), 8'h77);
            check("pend_d1", int'(cap[2]), 8'h22);
            check("pend_c1", int'(cap[3]), 8'hEE);
            check("pend_order", int'(clr_cyc > cap_cyc[1]), 1);
        end
        check("wr_while_busy", n_wr_busy, 0);

`ifdef SENSOR_NODE_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_addr(8'h01);
            wait_idle();
        end
        send_addr(8'h04);
        wait_idle();
        check("stats_poll", int'(poll_count), 3);
        check("stats_crc", int'(crc_tx_count), 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sensor_node.md
Name: sensor_node

Overview:
- Slave-side counterpart of the polling arbiter: one node per sensor on the shared UART link.
- Watches received address bytes; when its ID is polled, replies with a 2-byte frame: data byte, then CRC-8 byte.
- Reports a latched alarm by sending the inverted CRC.
- Sits between a byte-level UART (rdy/rdy_clr receive style, wr_en/tx_busy transmit style) and the local sensor sampling logic.

Parameters:
- NODE_ID, 3'd1, node address matched against received byte bits [2:0]; legal range 1..5.
- TURNAROUND, 4, clock cycles between address accept and first tx_wr (bus turnaround gap); legal range 1..255.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from UART
- rx_rdy  in  1  received byte valid; held until rx_clr
- rx_clr  out  1  one-cycle pulse acknowledging rx_data
- tx_data  out  8  byte to transmit
- tx_wr  out  1  one-cycle transmit strobe
- tx_busy  in  1  UART transmitter busy
- sensor_value  in  8  local sensor sample
- sensor_valid  in  1  sample strobe; sensor_value captured when high
- alarm  in  1  alarm event; any high cycle sets alarm latch
- alarm_pending  out  1  alarm latch state
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, active-high, one clock edge):
  - state=IDLE; rx_clr=0, tx_wr=0, tx_data=0, alarm_pending=0, busy=0; sample register=0.
  - Reset mid-frame abandons the frame; no further tx_wr is issued.
- Sample register: loaded with sensor_value on any cycle sensor_valid=1, in every state. The frame data byte is the register value copied at address accept; later samples do not affect the frame in flight.
- Alarm latch:
  - Set by alarm=1.
  - Cleared on acceptance of a broadcast address (rx_data[2:0]==0).
  - If set and cleared in the same cycle, set wins.
- CRC-8: polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB first, no reflection, no final XOR. Computed serially, one bit per cycle, over 8 cycles.
- States:
  - IDLE:
    - On rx_rdy=1: pulse rx_clr for one cycle and evaluate rx_data[2:0].
    - Equal to NODE_ID: copy sample into data register and go to CALC.
    - Equal to 0: clear alarm latch, stay IDLE (no reply).
    - Any other value: ignore, stay IDLE.
    - rx_data[7:3] is don't-care.
  - CALC: 8 cycles of serial CRC, then WAIT_TA.
  - WAIT_TA: counter runs from address accept. When TURNAROUND cycles have elapsed since accept (and CALC is done), go to SEND_D.
  - SEND_D:
    - Wait until tx_busy=0.
    - Then set tx_data=data and pulse tx_wr for one cycle; go to WAIT_D.
  - WAIT_D:
    - Wait for tx_busy=1, then for tx_busy=0.
    - If tx_busy has not risen within 4 cycles of tx_wr, treat the byte as sent.
    - Then go to SEND_C.
  - SEND_C: as SEND_D. Byte sent = crc when alarm_pending=0, ~crc when alarm_pending=1 (value sampled at this state). Go to WAIT_C.
  - WAIT_C: as WAIT_D, then IDLE.
- rx_rdy arriving while state != IDLE: rx_clr is not pulsed; the byte is processed on return to IDLE (one pending byte only).
- tx_wr never asserts in the same cycle as tx_busy=1.
- Minimum latency, address accept to data tx_wr: max(TURNAROUND, 9) cycles.

Optional Feature:
- Macro: SENSOR_NODE_STATS_EN
- Defined:
  - Extra output poll_count [15:0], reset 0.
  - Increments by 1 on each accepted own-ID address; saturates at 16'hFFFF (no wrap).
  - Also extra output crc_tx_count [15:0], incremented when the CRC byte tx_wr is issued; same reset and saturation rules.
- Undefined: ports and counters absent; the remaining behaviour is identical.

Test Plan:
- Reset, then sensor_valid with 0x01, then poll rx_data=0x01 (NODE_ID=1):
  - one rx_clr pulse;
  - tx bytes 0x01 then 0x07;
  - busy returns to 0 after the second tx_busy fall.
- Sample 0x80, alarm pulse, poll 0x01:
  - alarm_pending=1;
  - tx 0x80 then 0x76 (~0x89).
  - Then broadcast 0x00: rx_clr pulse, no tx_wr, alarm_pending=0.
- Poll 0x03 and 0xF2 (other IDs):
  - rx_clr pulses;
  - no tx_wr;
  - busy stays 0.
- tx_busy held high 50 cycles at SEND_D: tx_wr withheld until tx_busy falls, then issued exactly once. Also hold tx_busy low after tx_wr: 4-cycle fallback advances to the CRC byte.
- Reset asserted during WAIT_D:
  - outputs at reset values next cycle;
  - no CRC byte sent;
  - a new poll 0x01 produces a complete correct frame.
- Under SENSOR_NODE_STATS_EN, 3 own-ID polls plus 1 foreign poll: poll_count=3, crc_tx_count=3.
